// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request, response and ALU drive signals of the shared-ALU arbiter
interface alu_share_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
);
   logic [1:0]        req_valid_i;
   logic [1:0]        req_ready_o;
   logic [OP_W-1:0]   req0_op_i;
   logic [OP_W-1:0]   req1_op_i;
   logic [DATA_W-1:0] req0_a_i;
   logic [DATA_W-1:0] req1_a_i;
   logic [DATA_W-1:0] req0_b_i;
   logic [DATA_W-1:0] req1_b_i;
   logic [1:0]        rsp_valid_o;
   logic [1:0]        rsp_ready_i;
   logic [DATA_W-1:0] rsp_data_o;
   logic              rsp_zero_o;
   logic              rsp_branch_o;
   logic [DATA_W-1:0] alu_data1_o;
   logic [DATA_W-1:0] alu_data2_o;
   logic [OP_W-1:0]   alu_ctrl_o;
   logic [DATA_W-1:0] alu_data_i;
   logic              alu_zero_i;
   logic              alu_branch_i;
   logic              busy_o;

   modport slave (
      input  req_valid_i, req0_op_i, req1_op_i, req0_a_i, req1_a_i, req0_b_i, req1_b_i,
      input  rsp_ready_i, alu_data_i, alu_zero_i, alu_branch_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_branch_o,
      output alu_data1_o, alu_data2_o, alu_ctrl_o, busy_o
   );

   modport master (
      output req_valid_i, req0_op_i, req1_op_i, req0_a_i, req1_a_i, req0_b_i, req1_b_i,
      output rsp_ready_i, alu_data_i, alu_zero_i, alu_branch_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_branch_o,
      input  alu_data1_o, alu_data2_o, alu_ctrl_o, busy_o
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   alu_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state;
   logic              last_grant;
   logic              owner;
   logic              winner;
   logic [1:0]        grant;
   logic [OP_W-1:0]   op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_zero_q;
   logic              rsp_branch_q;
   logic [1:0]        rsp_valid_q;
   logic              busy_q;

   // With both ports valid the port that did not win last time goes next.
   always_comb begin
      winner = (bus.req_valid_i == 2'b11) ? ~last_grant : bus.req_valid_i[1];
      grant  = 2'b00;
      if (state == IDLE && |bus.req_valid_i) begin
         grant = winner ? 2'b10 : 2'b01;
      end
   end

   assign bus.req_ready_o  = grant;
   assign bus.rsp_valid_o  = rsp_valid_q;
   assign bus.rsp_data_o   = rsp_data_q;
   assign bus.rsp_zero_o   = rsp_zero_q;
   assign bus.rsp_branch_o = rsp_branch_q;
   assign bus.alu_ctrl_o   = op_q;
   assign bus.alu_data1_o  = a_q;
   assign bus.alu_data2_o  = b_q;
   assign bus.busy_o       = busy_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         owner        <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_branch_q <= 1'b0;
         rsp_valid_q  <= 2'b00;
         busy_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|bus.req_valid_i) begin
                  op_q       <= winner ? bus.req1_op_i : bus.req0_op_i;
                  a_q        <= winner ? bus.req1_a_i  : bus.req0_a_i;
                  b_q        <= winner ? bus.req1_b_i  : bus.req0_b_i;
                  owner      <= winner;
                  last_grant <= winner;
                  busy_q     <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_data_q   <= bus.alu_data_i;
               rsp_zero_q   <= bus.alu_zero_i;
               rsp_branch_q <= bus.alu_branch_i;
               rsp_valid_q  <= owner ? 2'b10 : 2'b01;
               state        <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready_i[owner]) begin
                  rsp_valid_q <= 2'b00;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, port 0 (execute stage) and port 1 (address/branch-compare unit).
- Each requester has a valid/ready operation channel and a valid/ready response channel.
- The block arbitrates round-robin, registers operands, and drives the ALU data and control inputs for one cycle.
- It captures data_o, Zero_o and branch_flag_o into response registers and returns them to the winning requester.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU data width.
- OP_W, 4, ALU control code width (ALUCtrl).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  2  per-port operation valid; bit k = port k.
- req_ready_o  out  2  per-port accept; one-hot or zero.
- req0_op_i, req1_op_i  in  OP_W  ALU control code per port.
- req0_a_i, req1_a_i  in  DATA_W  operand 1 per port.
- req0_b_i, req1_b_i  in  DATA_W  operand 2 per port.
- rsp_valid_o  out  2  per-port response valid; one-hot or zero.
- rsp_ready_i  in  2  per-port response accept.
- rsp_data_o  out  DATA_W  captured ALU result; shared by both ports.
- rsp_zero_o  out  1  captured Zero_o.
- rsp_branch_o  out  1  captured branch_flag_o.
- alu_data1_o, alu_data2_o  out  DATA_W  to ALU data1_i/data2_i.
- alu_ctrl_o  out  OP_W  to ALU ALUCtrl_i.
- alu_data_i  in  DATA_W  from ALU data_o.
- alu_zero_i  in  1  from ALU Zero_o.
- alu_branch_i  in  1  from ALU branch_flag_o.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_i low, asynchronous): state=IDLE, last_grant=1 (port 0 wins first), owner=0.
  - Operand/op registers = 0, so alu_data1_o/alu_data2_o/alu_ctrl_o = 0 (ADD of 0,0).
  - rsp_data_o=0, rsp_zero_o=0, rsp_branch_o=0, rsp_valid_o=0, req_ready_o=0, busy_o=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready_o is combinational: one-hot to the winner when any req_valid_i is set, else 0.
  - Winner: the sole valid port; if both are valid, the port != last_grant.
  - On accept edge: latch winner's op/a/b into the ALU drive registers; owner<=winner; last_grant<=winner; go to EXEC.
- EXEC (exactly 1 cycle):
  - The ALU sees the registered operands.
  - At the end of the cycle, capture alu_data_i, alu_zero_i and alu_branch_i into the rsp_* registers; go to RESP.
  - All three are captured unconditionally for every op code; the requester interprets them.
- RESP:
  - rsp_valid_o[owner]=1; rsp_* outputs are stable.
  - When rsp_ready_i[owner]=1 on a rising edge, return to IDLE.
  - rsp_ready_i of the non-owner port is ignored.
- Latency:
  - Accept at edge N, so rsp_valid_o is high from the cycle after edge N+1.
  - Minimum issue interval is 3 cycles (accept, EXEC, RESP with ready already high).
- ALU drive registers hold their value outside EXEC; they change only on accept.
- req_ready_o=0 in EXEC and RESP, even if requests are pending; no queuing.
- A requester must hold valid/op/a/b stable until accepted. Dropping valid before accept withdraws the request without side effect; last_grant is unchanged.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1…; neither port waits more than one transaction.
- rsp_ready_i already high on entry to RESP: rsp_valid_o is high exactly one cycle.
- Reset asserted mid-transaction: the transaction is discarded and every output returns to its reset value immediately; there is no response after release.
- Widths: DATA_W passes straight through with no extension or truncation; the result is taken as produced by the ALU.

Test Plan:
- Reset, then req_valid_i=01, op=ADD(0000), a=5, b=7.
  - Required: req_ready_o=01 in the same cycle; alu_ctrl_o=0000 in EXEC.
  - Required: rsp_valid_o=01 two edges after accept, rsp_data_o=12, rsp_zero_o=0.
- Both ports valid continuously.
  - Port 0: SUB, a=9, b=9. Port 1: XOR, a=0xF0, b=0x0F. rsp_ready_i=11.
  - Required: grant order 0,1,0,1.
  - Required: port 0 gets rsp_data_o=0, rsp_zero_o=1; port 1 gets rsp_data_o=0xFF.
- Port 1 BLT (1000), a=0xFFFFFFFF, b=1, rsp_ready_i=00 for 4 cycles then 10.
  - Required: rsp_valid_o=10 held 5 cycles; rsp_branch_o=1 stable throughout.
  - Required: port 0 request during that window sees req_ready_o=00.
- Port 0 asserts valid one cycle then drops it while port 1 is being serviced.
  - Required: no grant to port 0; last_grant stays 1.
- Reset pulsed low during RESP.
  - Required: rsp_valid_o=00, busy_o=0 and rsp_data_o=0 immediately.
  - Required: the next request after release follows the normal accept and latency sequence.
- Port 0 SRA (0101), a=0x80000000, b=4.
  - Required: rsp_data_o=0xF8000000, passed unchanged from alu_data_i.
